// File: rtl/dac_spi_writer.sv
// Latches two 12-bit DAC codes per sample strobe, sends them as MCP4922-style SPI frames
// (channel A then B) and pulses LDAC. Define DAC_SPI_OVERRUN_CNT_EN to add overrun_count.
module dac_spi_writer #(
    parameter int CLK_DIV       = 4,
    parameter int CS_GAP_CYCLES = 2,
    parameter int LDAC_CYCLES   = 2,
    parameter int GAIN_1X       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_sampling,
    input  logic        enableA,
    input  logic        enableB,
    input  logic [11:0] dacA_word,
    input  logic [11:0] dacB_word,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic        done,
    output logic        overrun
`ifdef DAC_SPI_OVERRUN_CNT_EN
    ,
    output logic [7:0]  overrun_count
`endif
);

    localparam int CNT_MAX = (CS_GAP_CYCLES > LDAC_CYCLES) ? CS_GAP_CYCLES : LDAC_CYCLES;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYCLES - 1);
    localparam logic             GAIN_BIT  = (GAIN_1X != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME_A,
        S_GAP,
        S_FRAME_B,
        S_PRE_LDAC,
        S_LDAC
    } state_t;

    // Command word: channel, BUF=0, GA_n, SHDN_n, data (data forced to 0 when shut down).
    function automatic logic [15:0] frame_word(input logic ch, input logic en,
                                               input logic [11:0] word);
        return {ch, 1'b0, GAIN_BIT, en, en ? word : 12'h000};
    endfunction

    state_t            state_q, state_d;
    logic              cs_active_q, cs_active_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        half_q, half_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       shift_q, shift_d;
    logic [11:0]       a_word_q, a_word_d;
    logic [11:0]       b_word_q, b_word_d;
    logic              a_en_q, a_en_d;
    logic              b_en_q, b_en_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              ldac_n_q, ldac_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              strobe_drop;
    logic              frame_live;
`ifdef DAC_SPI_OVERRUN_CNT_EN
    logic [7:0]        ovr_cnt_q, ovr_cnt_d;
`endif

    assign strobe_drop = clk_sampling && (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        cs_active_d = cs_active_q;
        div_d       = div_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        a_word_d    = a_word_q;
        b_word_d    = b_word_q;
        a_en_d      = a_en_q;
        b_en_d      = b_en_q;
        overrun_d   = overrun_q | strobe_drop;
`ifdef DAC_SPI_OVERRUN_CNT_EN
        ovr_cnt_d   = ovr_cnt_q;
        if (strobe_drop && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                if (clk_sampling) begin
                    a_word_d    = dacA_word;
                    b_word_d    = dacB_word;
                    a_en_d      = enableA;
                    b_en_d      = enableB;
                    cs_active_d = 1'b0;
                    state_d     = S_FRAME_A;
                end
            end
            S_FRAME_A, S_FRAME_B: begin
                if (!cs_active_q) begin
                    // Setup cycle: cs_n still high, word staged so bit15 leads the cs_n fall.
                    cs_active_d = 1'b1;
                    div_d       = '0;
                    half_d      = '0;
                    shift_d     = frame_word(1'b0, a_en_q, a_word_q);
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (half_q != 5'd31) begin
                        half_d = half_q + 5'd1;
                        // Odd half-periods are sclk high; leaving one is a falling edge.
                        if (half_q[0]) begin
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end else if (state_q == S_FRAME_A) begin
                        cs_active_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = S_GAP;
                    end else begin
                        cs_active_d = 1'b0;
                        state_d     = S_PRE_LDAC;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cs_active_d = 1'b1;
                    div_d       = '0;
                    half_d      = '0;
                    shift_d     = frame_word(1'b1, b_en_q, b_word_q);
                    state_d     = S_FRAME_B;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRE_LDAC: begin
                cnt_d   = '0;
                state_d = S_LDAC;
            end
            S_LDAC: begin
                if (cnt_q == LDAC_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up with state_q.
        frame_live = ((state_d == S_FRAME_A) || (state_d == S_FRAME_B)) && cs_active_d;
        cs_n_d     = !frame_live;
        sclk_d     = frame_live && half_d[0];
        mosi_d     = frame_live && shift_d[15];
        ldac_n_d   = (state_d != S_LDAC);
        done_d     = (state_d == S_LDAC) && (cnt_d == LDAC_LAST);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cs_active_q <= 1'b0;
            div_q       <= '0;
            half_q      <= '0;
            cnt_q       <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            ldac_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef DAC_SPI_OVERRUN_CNT_EN
            ovr_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cs_active_q <= cs_active_d;
            div_q       <= div_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            ldac_n_q    <= ldac_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
`ifdef DAC_SPI_OVERRUN_CNT_EN
            ovr_cnt_q   <= ovr_cnt_d;
`endif
        end
    end

    // Sample shadows and the shift register carry data only; the FSM decides when they matter.
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        a_word_q <= a_word_d;
        b_word_q <= b_word_d;
        a_en_q   <= a_en_d;
        b_en_q   <= b_en_d;
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign ldac_n  = ldac_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;
`ifdef DAC_SPI_OVERRUN_CNT_EN
    assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_dac_spi_writer.sv
// Scoreboard bench for dac_spi_writer: expected SPI frames are queued at stimulus time and
// compared when cs_n rises. A second instance covers CLK_DIV=2 with 2x gain.
module tb_dac_spi_writer;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_sampling = 1'b0;
    logic        clk_sampling2 = 1'b0;
    logic        enableA = 1'b0;
    logic        enableB = 1'b0;
    logic [11:0] dacA_word = 12'h000;
    logic [11:0] dacB_word = 12'h000;
    logic        sclk, mosi, cs_n, ldac_n, busy, done, overrun;
    logic        sclk2, mosi2, cs_n2, ldac_n2, busy2, done2, overrun2;
`ifdef DAC_SPI_OVERRUN_CNT_EN
    logic [7:0]  ovr_cnt, ovr_cnt2;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          viol = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp2_q[$];

    always #5 clk = ~clk;

    dac_spi_writer #(.CLK_DIV(CLK_DIV), .CS_GAP_CYCLES(2), .LDAC_CYCLES(2), .GAIN_1X(1)) dut (
        .clk(clk), .rst(rst), .clk_sampling(clk_sampling),
        .enableA(enableA), .enableB(enableB),
        .dacA_word(dacA_word), .dacB_word(dacB_word),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .ldac_n(ldac_n),
        .busy(busy), .done(done), .overrun(overrun)
`ifdef DAC_SPI_OVERRUN_CNT_EN
        , .overrun_count(ovr_cnt)
`endif
    );

    dac_spi_writer #(.CLK_DIV(2), .CS_GAP_CYCLES(2), .LDAC_CYCLES(2), .GAIN_1X(0)) dut2 (
        .clk(clk), .rst(rst), .clk_sampling(clk_sampling2),
        .enableA(enableA), .enableB(enableB),
        .dacA_word(dacA_word), .dacB_word(dacB_word),
        .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .ldac_n(ldac_n2),
        .busy(busy2), .done(done2), .overrun(overrun2)
`ifdef DAC_SPI_OVERRUN_CNT_EN
        , .overrun_count(ovr_cnt2)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Frame monitor for the main instance, sampled on the falling clock edge.
    initial begin
        logic        csn_prev = 1'b1;
        logic        sclk_prev = 1'b0;
        logic        mosi_prev = 1'b0;
        int          low_cnt = 0;
        int          rises = 0;
        logic [15:0] shw = 16'h0;
        logic [15:0] want;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_cnt = 0; rises = 0; shw = 16'h0;
                csn_prev = 1'b1; sclk_prev = 1'b0; mosi_prev = 1'b0;
                exp_q.delete();
            end else begin
                if (cs_n && (mosi || sclk)) viol++;
                if (!cs_n && !csn_prev && (mosi !== mosi_prev) && !(sclk_prev && !sclk)) viol++;
                if (!cs_n) begin
                    low_cnt++;
                    if (sclk && !sclk_prev) begin
                        shw = {shw[14:0], mosi};
                        rises++;
                    end
                end else if (!csn_prev) begin
                    check_eq("cs_low_cycles", low_cnt, 32 * CLK_DIV);
                    check_eq("sclk_rises", rises, 16);
                    check_eq("sclk_at_cs_rise", sclk, 0);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_frame", shw, 32'hFFFF_FFFF);
                    end else begin
                        want = exp_q.pop_front();
                        check_eq("frame_word", shw, want);
                    end
                    low_cnt = 0; rises = 0; shw = 16'h0;
                end
                csn_prev = cs_n; sclk_prev = sclk; mosi_prev = mosi;
            end
        end
    end

    // One full transfer on the main instance with timing checks; optional mid-transfer
    // input clobbering and an extra strobe at cycle 'extra'.
    task automatic run_xfer(input logic [11:0] a, input logic [11:0] b, input logic ea,
                            input logic eb, input logic [15:0] exp_a, input logic [15:0] exp_b,
                            input bit clobber, input int extra);
        int n, ldac_lo, done_at;
        exp_q.push_back(exp_a);
        exp_q.push_back(exp_b);
        dacA_word = a; dacB_word = b; enableA = ea; enableB = eb;
        clk_sampling = 1'b1;
        @(posedge clk); #1;
        clk_sampling = 1'b0;
        if (clobber) begin
            dacA_word = 12'h000; dacB_word = ~b; enableA = ~ea; enableB = ~eb;
        end
        check_eq("busy_after_accept", busy, 1);
        n = 1; ldac_lo = 0; done_at = 0;
        while (n < 400 && done_at == 0) begin
            if (!ldac_n) ldac_lo++;
            if (done) done_at = n;
            clk_sampling = (n == extra);
            @(posedge clk); #1;
            n++;
        end
        clk_sampling = 1'b0;
        check_eq("done_cycle", done_at, 262);
        check_eq("ldac_low_cycles", ldac_lo, 2);
        check_eq("busy_after_done", busy, 0);
        check_eq("ldac_released", ldac_n, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic capture2(output logic [15:0] w, output int low, output int rises,
                            output logic fell);
        int   guard;
        logic sp;
        w = 16'h0; low = 0; rises = 0; guard = 0; sp = 1'b0;
        while (cs_n2 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        fell = !cs_n2;
        while (!cs_n2 && guard < 400) begin
            if (sclk2 && !sp) begin
                w = {w[14:0], mosi2};
                rises++;
            end
            sp = sclk2;
            low++;
            @(posedge clk); #1; guard++;
        end
    endtask

    initial begin
        int          n, drops, low, r, guard;
        logic [15:0] w, want;
        logic        fell;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs_n", cs_n, 1);
        check_eq("rst_ldac_n", ldac_n, 1);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_mosi", mosi, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_overrun", overrun, 0);
`ifdef DAC_SPI_OVERRUN_CNT_EN
        check_eq("rst_ovr_count", ovr_cnt, 0);
`endif
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_xfer(12'hABC, 12'h123, 1'b1, 1'b1, 16'h3ABC, 16'hB123, 1'b0, 0);
        run_xfer(12'hFFF, 12'h555, 1'b1, 1'b0, 16'h3FFF, 16'hA000, 1'b0, 0);
        run_xfer(12'hABC, 12'h123, 1'b1, 1'b1, 16'h3ABC, 16'hB123, 1'b1, 0);
        check_eq("overrun_before_drop", overrun, 0);

        run_xfer(12'h800, 12'h7FF, 1'b1, 1'b1, 16'h3800, 16'hB7FF, 1'b0, 100);
        check_eq("overrun_set", overrun, 1);
`ifdef DAC_SPI_OVERRUN_CNT_EN
        check_eq("ovr_count_one", ovr_cnt, 1);
`endif
        repeat (300) @(posedge clk);
        #1;
        check_eq("no_frame_from_drop", exp_q.size(), 0);
        check_eq("idle_after_drop", busy, 0);
        check_eq("overrun_sticky", overrun, 1);

`ifdef DAC_SPI_OVERRUN_CNT_EN
        drops = 0;
        repeat (2) begin
            exp_q.push_back(16'h3001);
            exp_q.push_back(16'hBFFE);
            dacA_word = 12'h001; dacB_word = 12'hFFE; enableA = 1'b1; enableB = 1'b1;
            clk_sampling = 1'b1;
            @(posedge clk); #1;
            guard = 0;
            while (busy && guard < 1000) begin
                clk_sampling = 1'b1;
                drops++;
                @(posedge clk); #1;
                guard++;
            end
            clk_sampling = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        check_eq("drops_issued", (drops >= 300), 1);
        check_eq("ovr_count_sat", ovr_cnt, 255);
        check_eq("overrun_still_set", overrun, 1);
`endif

        // Reset in the middle of frame B.
        exp_q.push_back(16'h3456);
        exp_q.push_back(16'hB789);
        dacA_word = 12'h456; dacB_word = 12'h789; enableA = 1'b1; enableB = 1'b1;
        clk_sampling = 1'b1;
        @(posedge clk); #1;
        clk_sampling = 1'b0;
        n = 1;
        while (n < 180) begin
            @(posedge clk); #1; n++;
        end
        check_eq("mid_frame_b_cs_low", cs_n, 0);
        rst = 1'b1;
        #1;
        check_eq("abort_cs_n", cs_n, 1);
        check_eq("abort_sclk", sclk, 0);
        check_eq("abort_ldac_n", ldac_n, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_xfer(12'h5A5, 12'h0F0, 1'b0, 1'b1, 16'h2000, 16'hB0F0, 1'b0, 0);

        // Fast-clock, 2x-gain instance.
        exp2_q.push_back(16'h1ABC);
        exp2_q.push_back(16'h9123);
        dacA_word = 12'hABC; dacB_word = 12'h123; enableA = 1'b1; enableB = 1'b1;
        clk_sampling2 = 1'b1;
        @(posedge clk); #1;
        clk_sampling2 = 1'b0;
        for (int f = 0; f < 2; f++) begin
            capture2(w, low, r, fell);
            check_eq("d2_cs_fell", fell, 1);
            check_eq("d2_cs_low_cycles", low, 64);
            check_eq("d2_sclk_rises", r, 16);
            want = exp2_q.pop_front();
            check_eq("d2_frame_word", w, want);
        end
        guard = 0;
        while (busy2 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        check_eq("d2_idle", busy2, 0);
        check_eq("d2_overrun", overrun2, 0);

        repeat (5) @(posedge clk);
        #1;
        check_eq("idle_line_rules", viol, 0);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
